// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame marker bytes and the
// default timing/size constants used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] UART_HDR       = 8'hFA;
    localparam logic [7:0] UART_TAIL      = 8'hFD;
    localparam int         UART_CLK_DIV   = 434;
    localparam int         UART_NUM_BYTES = 48;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 while enabled and flags the last cycle
// of each bit with bit_end; held at zero while disabled.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = UART_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_end
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] baud_cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            baud_cnt <= '0;
        end else if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    assign bit_end = en && (baud_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_48bytes.sv
// Multi-byte 8N1 transmitter: sends a NUM_BYTES*8-bit frame MSB byte first, each
// byte LSB first. Define UART_TX_AUTO_HDR_EN to force the 0xFA header / 0xFD tail.
//
// state | meaning
// IDLE  | line high, waiting for start
// START | start bit (low) of the current byte
// DATA  | 8 data bits of the top byte, LSB first
// STOP  | stop bit (high); next byte or end of frame
module uart_tx_48bytes
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = UART_CLK_DIV,
    parameter int NUM_BYTES = UART_NUM_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_BYTES*8-1:0] frame_in,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);

    localparam int            W         = NUM_BYTES * 8;
    localparam int            BW        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

    tx_state_t       state_q, state_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [W-1:0]    frame_lat;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [BW-1:0]   byte_idx_q, byte_idx_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            bit_end;
    logic [7:0]      top_byte;

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q != IDLE),
        .bit_end (bit_end)
    );

    always_comb begin
        frame_lat = frame_in;
`ifdef UART_TX_AUTO_HDR_EN
        frame_lat[W-1 -: 8] = UART_HDR;
        frame_lat[7:0]      = UART_TAIL;
`endif
    end

    assign top_byte = shreg_q[W-1 -: 8];

    // tx_d is computed from the transition being taken so the line is registered
    // and already shows the new bit in the first cycle of each state.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    shreg_d    = frame_lat;
                    byte_idx_d = '0;
                    state_d    = START;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = top_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = top_byte[bit_idx_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx_q != LAST_BYTE) begin
                        shreg_d    = shreg_q << 8;
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_48bytes.sv
// Bench for uart_tx_48bytes at CLK_DIV=4: decodes the serial line back into bytes
// and compares against a byte-slicing model of the frame.
module tb_uart_tx_48bytes;

    localparam int DIV       = 4;
    localparam int NB        = 48;
    localparam int W         = NB * 8;
    localparam int BITS      = NB * 10;
    localparam int FRAME_CYC = BITS * DIV;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] frame_in;
    logic         tx, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    logic       samp_tx   [0:4095];
    logic       samp_busy [0:4095];
    logic       samp_done [0:4095];
    logic [7:0] dec       [0:NB-1];

    typedef struct {
        string        name;
        logic [W-1:0] frame;
        logic [7:0]   exp_first;
        logic [7:0]   exp_last;
    } vec_t;

    vec_t vecs [0:4];

    uart_tx_48bytes #(.CLK_DIV(DIV), .NUM_BYTES(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .frame_in (frame_in),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Byte k of the frame as it should appear on the line (k=0 goes first).
    function automatic logic [7:0] model_byte(input logic [W-1:0] f, input int k);
`ifdef UART_TX_AUTO_HDR_EN
        if (k == 0) return 8'hFA;
        if (k == NB - 1) return 8'hFD;
`endif
        return 8'(f >> (8 * (NB - 1 - k)));
    endfunction

    // Samples one value per cycle at the falling edge. Sample 0 is the cycle
    // after the accept edge. Optionally pokes start/frame_in at poke_idx.
    task automatic capture(input int n, input bit hold, input int poke_idx,
                           input bit poke_start, input logic [W-1:0] poke_frame);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            samp_tx[i]   = tx;
            samp_busy[i] = busy;
            samp_done[i] = done;
            if (i == 0) begin
                if (!hold) start = 1'b0;
                frame_in = ~frame_in;
            end
            if (i == poke_idx) begin
                start    = poke_start;
                frame_in = poke_frame;
            end else if (i == poke_idx + 1) begin
                start = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input int off, input logic [W-1:0] f, input string name);
        bit hold_ok = 1, frm_ok = 1, busy_ok = 1, quiet_ok = 1;
        for (int j = 0; j < BITS; j++)
            for (int s = 1; s < DIV; s++)
                if (samp_tx[off + DIV*j + s] !== samp_tx[off + DIV*j]) hold_ok = 0;
        for (int k = 0; k < NB; k++) begin
            int bb = off + 10 * DIV * k;
            if (samp_tx[bb] !== 1'b0) frm_ok = 0;
            if (samp_tx[bb + 9*DIV] !== 1'b1) frm_ok = 0;
            for (int b = 0; b < 8; b++) dec[k][b] = samp_tx[bb + DIV*(1 + b)];
            chk($sformatf("%s byte%0d", name, k), 32'(dec[k]), 32'(model_byte(f, k)));
        end
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (samp_busy[off + i] !== 1'b1) busy_ok = 0;
            if (samp_done[off + i] !== 1'b0) quiet_ok = 0;
        end
        chk({name, " bit_hold"}, 32'(hold_ok), 32'd1);
        chk({name, " framing"}, 32'(frm_ok), 32'd1);
        chk({name, " busy_during"}, 32'(busy_ok), 32'd1);
        chk({name, " done_quiet"}, 32'(quiet_ok), 32'd1);
        chk({name, " done_end"}, 32'(samp_done[off + FRAME_CYC]), 32'd1);
        chk({name, " busy_end"}, 32'(samp_busy[off + FRAME_CYC]), 32'd0);
        chk({name, " tx_end"}, 32'(samp_tx[off + FRAME_CYC]), 32'd1);
    endtask

    task automatic check_quiet(input int from, input int to, input string name);
        bit ok = 1;
        for (int i = from; i <= to; i++)
            if (samp_tx[i] !== 1'b1 || samp_busy[i] !== 1'b0 || samp_done[i] !== 1'b0) ok = 0;
        chk({name, " idle_after"}, 32'(ok), 32'd1);
    endtask

    logic [W-1:0] fa, fb;
    bit           any_done;

    initial begin
        vecs[0].name = "pattern";
        for (int k = 0; k < NB; k++)
            vecs[0].frame[W-1-8*k -: 8] = (k == 0) ? 8'hFA : (k == NB-1) ? 8'hFD : 8'(k);
        vecs[0].exp_first = 8'hFA;
        vecs[0].exp_last  = 8'hFD;
        vecs[1].name = "zeros"; vecs[1].frame = '0;
        vecs[1].exp_first = 8'h00; vecs[1].exp_last = 8'h00;
        vecs[2].name = "ones"; vecs[2].frame = '1;
        vecs[2].exp_first = 8'hFF; vecs[2].exp_last = 8'hFF;
        vecs[3].name = "alt55"; vecs[3].frame = {NB{8'h55}};
        vecs[3].exp_first = 8'h55; vecs[3].exp_last = 8'h55;
        vecs[4].name = "random";
        for (int k = 0; k < NB; k++) vecs[4].frame[8*k +: 8] = 8'($urandom);
        vecs[4].exp_first = vecs[4].frame[W-1 -: 8];
        vecs[4].exp_last  = vecs[4].frame[7:0];
`ifdef UART_TX_AUTO_HDR_EN
        for (int i = 0; i < 5; i++) begin
            vecs[i].exp_first = 8'hFA;
            vecs[i].exp_last  = 8'hFD;
        end
`endif

        rst = 1'b1; start = 1'b0; frame_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk($sformatf("reset_idle tx c%0d", i), 32'(tx), 32'd1);
            chk($sformatf("reset_idle busy c%0d", i), 32'(busy), 32'd0);
            chk($sformatf("reset_idle done c%0d", i), 32'(done), 32'd0);
        end

        for (int v = 0; v < 5; v++) begin
            start = 1'b1; frame_in = vecs[v].frame;
            capture(FRAME_CYC + 10, 1'b0, -5, 1'b0, '0);
            check_frame(0, vecs[v].frame, vecs[v].name);
            chk({vecs[v].name, " first"}, 32'(dec[0]), 32'(vecs[v].exp_first));
            chk({vecs[v].name, " last"}, 32'(dec[NB-1]), 32'(vecs[v].exp_last));
            check_quiet(FRAME_CYC + 1, FRAME_CYC + 9, vecs[v].name);
        end

        // start plus a new frame_in during byte 10 must be ignored
        for (int k = 0; k < NB; k++) fa[8*k +: 8] = 8'($urandom);
        fb = ~fa;
        start = 1'b1; frame_in = fa;
        capture(FRAME_CYC + 20, 1'b0, 10 * 10 * DIV, 1'b1, fb);
        check_frame(0, fa, "midstart");
        check_quiet(FRAME_CYC + 1, FRAME_CYC + 19, "midstart");

        // reset in the middle of byte 5's data bits
        start = 1'b1; frame_in = '0;
        any_done = 0;
        for (int i = 0; i < 210; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (done) any_done = 1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midreset tx", 32'(tx), 32'd1);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || !tx || busy) any_done = 1;
        end
        chk("midreset no_done", 32'(any_done), 32'd0);
        for (int k = 0; k < NB; k++) fa[8*k +: 8] = 8'($urandom);
        start = 1'b1; frame_in = fa;
        capture(FRAME_CYC + 10, 1'b0, -5, 1'b0, '0);
        check_frame(0, fa, "after_reset");

        // start held high: second frame accepted in the done cycle
        for (int k = 0; k < NB; k++) fa[8*k +: 8] = 8'($urandom);
        start = 1'b1; frame_in = fa;
        capture(2 * (FRAME_CYC + 1) + 10, 1'b1, FRAME_CYC + 5, 1'b0, ~fa);
        check_frame(0, fa, "held1");
        check_frame(FRAME_CYC + 1, ~fa, "held2");
        check_quiet(2 * (FRAME_CYC + 1), 2 * (FRAME_CYC + 1) + 9, "held2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_48bytes.md
# uart_tx_48bytes

Serial transmitter that sends one 384-bit frame as 48 consecutive 8N1 UART bytes on a single line. It sits directly upstream of the 48-byte UART receiver: its `tx` output drives that receiver's `Rx`. Its byte order is chosen so the frame reassembles bit-exact in the receiver's 384-bit register: first byte sent lands in [383:376], last byte in [7:0]. The receiver's 0xFA header / 0xFD tail check therefore passes for a well-formed frame.

## Interface
- `CLK_DIV`, default 434: clock cycles per UART bit. 434 gives 115200 bps at 50 MHz. Legal range 4..65535.
- `NUM_BYTES`, default 48: bytes per frame. Frame width is NUM_BYTES*8.
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request to send `frame_in`. Sampled only in IDLE.
- `frame_in`  in  NUM_BYTES*8: frame to send. Byte [383:376] goes first.
- `tx`  out  1: serial line. Idle high.
- `busy`  out  1: high from the cycle after `start` is accepted until the frame ends.
- `done`  out  1: one-cycle pulse after the last stop bit completes.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0. FSM goes to IDLE; all counters and the shift register are cleared.
- FSM states:
  - IDLE: `tx`=1, `busy`=0. On `start`=1, latch `frame_in` into the shift register and go to START.
  - START: drive `tx`=0 for CLK_DIV cycles, then go to DATA.
  - DATA: send the top byte of the shift register, LSB first. Each of the 8 bits is held for CLK_DIV cycles. Then go to STOP.
  - STOP: drive `tx`=1 for CLK_DIV cycles.
    - If byte_idx < NUM_BYTES-1: shift the register left by 8, increment byte_idx, return to START.
    - Otherwise: assert `done` for one cycle and return to IDLE.
- Counters:
  - baud_cnt runs 0..CLK_DIV-1 and wraps to 0 on every bit boundary.
  - bit_idx runs 0..7.
  - byte_idx runs 0..NUM_BYTES-1 and is ceil(log2(NUM_BYTES)) wide.
- `frame_in` is sampled only on the accept cycle. Later changes to it do not affect the frame in flight.
- `start` while `busy`=1 is ignored; it is not queued.
- `start` held high continuously: a new frame is accepted in the first IDLE cycle after `done`. The line then sees exactly one stop-bit gap between the last byte and the next start bit.
- Reset mid-frame: on the next edge, `tx`=1, `busy`=0, state is IDLE and no `done` pulse is produced. The receiver sees a truncated frame, which its header/tail check rejects.

## Timing
- Accept at edge N (IDLE, `start`=1): `busy`=1 and `tx`=0 from edge N+1.
- Each byte takes 10*CLK_DIV cycles.
- Whole frame takes NUM_BYTES*10*CLK_DIV cycles (208320 at defaults), measured from the first `tx`=0 cycle to the end of the last stop bit.
- End of frame: `done`=1 and `busy`=0 in the same cycle, i.e. the cycle after the last stop-bit cycle. `done` lasts exactly one cycle.
- Earliest re-accept is that `done` cycle, when the FSM is already in IDLE.
- `tx` is a registered output with no combinational path from any input.

## Configuration
- `UART_TX_AUTO_HDR_EN` defined:
  - the first transmitted byte is forced to 0xFA;
  - the last transmitted byte is forced to 0xFD;
  - `frame_in` [383:376] and [7:0] are ignored.
  - The forcing is applied at latch time.
- Not defined: all 48 bytes are taken from `frame_in` unchanged.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - the header constant 0xFA and tail constant 0xFD;
  - the default CLK_DIV and NUM_BYTES constants, shared with the receiver.
- Sub-module `uart_baud_gen`:
  - contains the baud counter;
  - has an enable input;
  - emits a one-cycle `bit_end` tick when the count reaches CLK_DIV-1;
  - is cleared while disabled.
- The FSM, shift register and byte/bit counters stay in the top module.

## Test plan
- Reset, then idle 100 cycles → `tx`=1, `busy`=0, `done`=0 throughout.
- CLK_DIV=4, frame = 0xFA, 0x01..0x2E, 0xFD, one `start` pulse:
  - each byte is decoded from `tx` as start 0, LSB-first data, stop 1, with every bit exactly 4 cycles;
  - `done` pulses once, 1920 cycles after the first start bit begins.
- Loop-back into the receiver at CLK_DIV=434 with a 50 MHz clock → receiver `Uart_Data` equals the sent frame after `done`.
- `start` pulsed at byte 10 mid-frame, with `frame_in` changed at the same time → ignored; the transmitted frame is unchanged and there is a single `done`.
- Assert `rst` during DATA of byte 5 → `tx`=1 and `busy`=0 on the next edge, no `done`; a following `start` sends a complete frame.
- With `UART_TX_AUTO_HDR_EN` and `frame_in` all zeros → first byte 0xFA, last byte 0xFD, the 46 middle bytes 0x00.
